// File: rtl/mem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// mem_lsu_pkg
//   Shared definitions for the mem_lsu load/store unit:
//   - op_e     : request opcodes OP_LW..OP_SB (3-bit encoding used on req_op)
//   - state_e  : LSU control states IDLE, RD, WR, RESP
//   - is_load  : true for the five load opcodes
//   - is_misaligned : alignment rule per access size
//   Endianness (macro LSU_BIG_ENDIAN_EN) only affects mem_lsu_lane.
// -----------------------------------------------------------------------------
package mem_lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    function automatic logic is_load(input op_e op);
        return (op != OP_SW) && (op != OP_SH) && (op != OP_SB);
    endfunction

    // Words need addr[1:0]==0, halves need addr[0]==0, bytes never misalign.
    function automatic logic is_misaligned(input op_e op, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LW, OP_SW:         mis = (lo != 2'b00);
            OP_LH, OP_LHU, OP_SH: mis = lo[0];
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// -----------------------------------------------------------------------------
// mem_lsu_if
//   Request/response handshake bundle between the EX/MEM stage (master) and
//   the LSU (slave).
//   req_valid/req_ready : request handshake, req_op/req_addr/req_wdata payload
//   rsp_valid/rsp_ready : response handshake, rsp_rdata/rsp_err payload
// -----------------------------------------------------------------------------
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_lsu_lane.sv
// -----------------------------------------------------------------------------
// mem_lsu_lane
//   Pure combinational lane logic for the LSU.
//   Ports: op (request opcode), lane (addr[1:0]), word (memory read data),
//          wdata (store data), load_data (extracted and extended load value),
//          merged (word with the store's target lane replaced).
//   Macro LSU_BIG_ENDIAN_EN: byte lane 0 = bits 31:24, half lane 0 = 31:16.
//   Undefined: little-endian, byte lane 0 = bits 7:0, half lane 0 = 15:0.
// -----------------------------------------------------------------------------
module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [1:0]         bsel;
    logic               hsel;
    logic signed [7:0]  byte_v;
    logic signed [15:0] half_v;

    always_comb begin
`ifdef LSU_BIG_ENDIAN_EN
        bsel = 2'd3 - lane;
        hsel = ~lane[1];
`else
        bsel = lane;
        hsel = lane[1];
`endif
        byte_v = word[{bsel, 3'b000} +: 8];
        half_v = word[{hsel, 4'b0000} +: 16];

        case (op)
            OP_LH:   load_data = 32'(half_v);
            OP_LHU:  load_data = {16'h0000, half_v};
            OP_LB:   load_data = 32'(byte_v);
            OP_LBU:  load_data = {24'h000000, byte_v};
            default: load_data = word;
        endcase

        merged = word;
        case (op)
            OP_SW:   merged = wdata;
            OP_SH:   merged[{hsel, 4'b0000} +: 16] = wdata[15:0];
            OP_SB:   merged[{bsel, 3'b000} +: 8]   = wdata[7:0];
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu
//   Load/store initiator for the 32-word data memory of the MIPS EX/MEM stage.
//   One word/half/byte access per request; sub-word stores are done as
//   read-modify-write, sub-word loads are sign/zero extended.
//   Ports:
//     clk, rst_n  : clock (rising edge), asynchronous active-low reset
//     bus         : mem_lsu_if.slave request/response handshakes
//     MemRead     : memory read strobe (RD state only)
//     MemWrite    : memory write strobe (WR state only)
//     dir         : word index req_addr[IDX_W+1:2], zero-extended
//     dataInput   : word to write
//     result      : memory read data, valid while MemRead=1
//   Macro LSU_BIG_ENDIAN_EN selects big-endian lanes (see mem_lsu_lane).
// -----------------------------------------------------------------------------
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_lsu_if.slave    bus,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] dir,
    output logic [31:0] dataInput,
    input  logic [31:0] result
);

    state_e      state_q, state_d;
    op_e         op_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    op_e         op_in;
    logic        accept;
    logic        req_err;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    assign op_in     = op_e'(bus.req_op);
    assign accept    = bus.req_valid && bus.req_ready;
    assign req_err   = is_misaligned(op_in, bus.req_addr[1:0]) ||
                       ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH));

    assign bus.req_ready = (state_q == IDLE) && rst_n;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    mem_lsu_lane u_lane (
        .op        (op_q),
        .lane      (lane_q),
        .word      (result),
        .wdata     (wdata_q),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Strobes decode straight from the state register so reset drops them
    // asynchronously.
    always_comb begin
        state_d  = state_q;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)             state_d = RESP;
                    else if (op_in == OP_SW) state_d = WR;
                    else                     state_d = RD;
                end
            end
            RD: begin
                MemRead = 1'b1;
                state_d = is_load(op_q) ? RESP : WR;
            end
            WR: begin
                MemWrite = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch at accept; read data or merged word captured at the end of RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_LW;
            lane_q    <= 2'b00;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            dir       <= 32'h0;
            dataInput <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_in;
                        lane_q  <= bus.req_addr[1:0];
                        wdata_q <= bus.req_wdata;
                        rdata_q <= 32'h0;
                        err_q   <= req_err;
                        dir     <= {{(32-IDX_W){1'b0}}, bus.req_addr[IDX_W+1:2]};
                        if (op_in == OP_SW) dataInput <= bus.req_wdata;
                    end
                end
                RD: begin
                    if (is_load(op_q)) rdata_q   <= lane_load;
                    else               dataInput <= lane_merged;
                end
                default: ;
            endcase
        end
    end

endmodule
